srff_seq_ctrl: RTL and testbench
================================

SRFF_SEQ_CTRL -- requirements
Module: srff_seq_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, giving command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 16, giving toggle counter width.
REQ-003 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have wr_en  input  1  push {wr_sr, wr_hold} into command FIFO.
REQ-006 SHALL have wr_sr  input  2  SR command; bit1 = S, bit0 = R.
REQ-007 SHALL have wr_hold  input  4  extra cycles to hold command (0 = 1 cycle).
REQ-008 SHALL have full / empty  output  1 each  FIFO status, combinational from occupancy.
REQ-009 SHALL have start  input  1  request playback of FIFO contents.
REQ-010 SHALL have busy / done  output  1 each  playback active / one-cycle completion pulse.
REQ-011 SHALL have sr_out  output  2  drives the srff sr port.
REQ-012 SHALL have q_in  input  1  srff q output, fed back for activity counting.
REQ-013 SHALL have toggle_cnt  output  CNT_W  q_in transitions during playback.
REQ-014 SHALL have illegal_cnt  output  8  cycles with sr_out = 2'b11 during playback.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE: start=1 and empty=0 -> RUN; start with empty=1 or in RUN/DONE SHALL be ignored.
REQ-017 Accepted start at edge N SHALL pop the head entry; from cycle N+1, sr_out = entry sr, busy = 1.
REQ-018 Each entry SHALL drive sr_out for exactly wr_hold+1 cycles (4-bit down-counter).
REQ-019 RUN, hold count 0, FIFO non-empty: pop next entry; sr_out changes next cycle with no gap.
REQ-020 RUN, hold count 0, FIFO empty: -> DONE; DONE lasts one cycle with done = 1, busy = 0, sr_out = 2'b00, then -> IDLE.
REQ-021 sr_out SHALL be 2'b00 (hold) in IDLE and DONE.
REQ-022 Writes SHALL be accepted in any state when full=0; wr_en with full=1 and no same-cycle pop SHALL be dropped silently.
REQ-023 Same-cycle push and pop when full SHALL both take effect (occupancy unchanged).
REQ-024 Push into an empty FIFO SHALL not be poppable until the following cycle.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
REQ-026 toggle_cnt and illegal_cnt SHALL clear on the accepted start edge.
REQ-027 q_in SHALL be registered once; toggle_cnt increments when busy=1 and q_in != registered q_in.
REQ-028 illegal_cnt SHALL increment each busy cycle with sr_out = 2'b11.
REQ-029 Both counters SHALL saturate at all-ones and hold their values through DONE and IDLE.

Reset
REQ-030 rst=1 SHALL force state IDLE, FIFO empty, pointers 0, hold count 0, sr_out 00, busy 0, done 0, counters 0, registered q 0, regardless of clk.
REQ-031 Reset mid-RUN SHALL discard all queued entries; no done pulse SHALL be produced.

Structure
REQ-032 Shared package srff_seq_pkg SHALL hold SR constants (SR_HOLD 00, SR_RESET 01, SR_SET 10, SR_ILLEGAL 11), FSM state encoding, and the 6-bit entry width.
REQ-033 FIFO SHALL be a sub-module srff_seq_fifo (DEPTH, width 6, full/empty, async reset); FSM and counters stay in srff_seq_ctrl.

Verification
REQ-034 Push {10,h0},{01,h2},{10,h1}; start -> sr_out 10 for 1, 01 for 3, 10 for 2 cycles; done pulse on cycle 7 after start; toggle_cnt = 3 with srff connected.
REQ-035 Push 9 entries at DEPTH=8 -> full=1 after 8th; 9th dropped; playback shows 8 entries only.
REQ-036 Push {11,h4}; start -> sr_out 11 for 5 cycles; illegal_cnt = 5.
REQ-037 Start with empty FIFO -> busy stays 0, no done pulse; push during RUN at occupancy 0 -> entry played contiguously after current.
REQ-038 Assert rst for 3 ns mid-RUN between clock edges -> sr_out, busy, counters 0 immediately; empty = 1.
REQ-039 Force 70000 toggles on q_in at CNT_W=16 -> toggle_cnt = 16'hFFFF, no wrap.

Source files
------------

// File: rtl/srff_seq_pkg.sv
// Shared constants and types for the SR flip-flop sequencer: SR command codes,
// FSM encoding and the packed command-FIFO entry layout.
`timescale 1ns/1ps
package srff_seq_pkg;

    localparam logic [1:0] SR_HOLD    = 2'b00;
    localparam logic [1:0] SR_RESET   = 2'b01;
    localparam logic [1:0] SR_SET     = 2'b10;
    localparam logic [1:0] SR_ILLEGAL = 2'b11;

    localparam int ENTRY_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // sr sits in the upper bits so {wr_sr, wr_hold} maps directly onto an entry
    typedef struct packed {
        logic [1:0] sr;
        logic [3:0] hold;
    } entry_t;

endpackage

// File: rtl/srff_seq_fifo.sv
// Command FIFO with show-ahead read data; a push while full is accepted only
// when a pop happens in the same cycle.
`timescale 1ns/1ps
module srff_seq_fifo
    import srff_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (occ == OCC_FULL);
    assign empty = (occ == '0);

endmodule

// File: rtl/srff_seq_ctrl.sv
// Plays queued SR commands onto an SR flip-flop, each held for hold+1 cycles,
// and counts q activity and illegal SR cycles during playback.
//
// state   | meaning
// IDLE    | sr_out held at 00, waiting for start with a non-empty FIFO
// RUN     | driving the current entry, popping the next when hold reaches 0
// DONE    | single-cycle completion pulse, then back to IDLE
`timescale 1ns/1ps
module srff_seq_ctrl
    import srff_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [1:0]       wr_sr,
    input  logic [3:0]       wr_hold,
    output logic             full,
    output logic             empty,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [1:0]       sr_out,
    input  logic             q_in,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [7:0]       illegal_cnt
);

    state_t               state;
    state_t               state_nxt;
    logic [3:0]           hold_cnt;
    logic [1:0]           sr_reg;
    logic [ENTRY_W-1:0]   head_raw;
    entry_t               head;
    logic                 accept_start;
    logic                 pop;
    logic                 q_reg;

    srff_seq_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .din   ({wr_sr, wr_hold}),
        .pop   (pop),
        .dout  (head_raw),
        .full  (full),
        .empty (empty)
    );

    assign head         = entry_t'(head_raw);
    assign accept_start = (state == ST_IDLE) && start && !empty;
    assign pop          = accept_start || ((state == ST_RUN) && (hold_cnt == 4'd0) && !empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept_start) state_nxt = ST_RUN;
            ST_RUN:  if ((hold_cnt == 4'd0) && empty) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == ST_RUN);
        done   = (state == ST_DONE);
        sr_out = busy ? sr_reg : SR_HOLD;
    end

    // hold_cnt is a down-counter; reaching zero marks the last cycle of an entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_reg   <= SR_HOLD;
            hold_cnt <= 4'd0;
        end else if (pop) begin
            sr_reg   <= head.sr;
            hold_cnt <= head.hold;
        end else if (hold_cnt != 4'd0) begin
            hold_cnt <= hold_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg       <= 1'b0;
            toggle_cnt  <= '0;
            illegal_cnt <= '0;
        end else begin
            q_reg <= q_in;
            if (accept_start) begin
                toggle_cnt  <= '0;
                illegal_cnt <= '0;
            end else if (busy) begin
                if ((q_in != q_reg) && (toggle_cnt != '1))
                    toggle_cnt <= toggle_cnt + CNT_W'(1);
                if ((sr_out == SR_ILLEGAL) && (illegal_cnt != 8'hFF))
                    illegal_cnt <= illegal_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_srff_seq_ctrl.sv
// Directed bench for srff_seq_ctrl: expected sr_out streams are queued as
// commands are pushed and consumed cycle by cycle during playback.
`timescale 1ns/1ps
module tb_srff_seq_ctrl;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [1:0]       wr_sr;
    logic [3:0]       wr_hold;
    logic             full;
    logic             empty;
    logic             start;
    logic             busy;
    logic             done;
    logic [1:0]       sr_out;
    logic             q_in;
    logic [CNT_W-1:0] toggle_cnt;
    logic [7:0]       illegal_cnt;

    logic             q_srff;
    logic             q_force;
    logic             q_sel;

    int vectors     = 0;
    int miscompares = 0;
    logic [1:0] exp_q[$];
    int model_occ = 0;
    int dc;

    srff_seq_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_sr       (wr_sr),
        .wr_hold     (wr_hold),
        .full        (full),
        .empty       (empty),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .sr_out      (sr_out),
        .q_in        (q_in),
        .toggle_cnt  (toggle_cnt),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    // behavioural SR flip-flop closing the q feedback loop
    always @(posedge clk or posedge rst) begin
        if (rst) q_srff <= 1'b0;
        else if (sr_out == 2'b10) q_srff <= 1'b1;
        else if (sr_out == 2'b01) q_srff <= 1'b0;
    end

    assign q_in = q_sel ? q_force : q_srff;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] sr, input logic [3:0] h);
        wr_en   = 1'b1;
        wr_sr   = sr;
        wr_hold = h;
        if (model_occ < DEPTH) begin
            model_occ++;
            repeat (int'(h) + 1) exp_q.push_back(sr);
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic play(input int push_at, input logic [1:0] psr, input logic [3:0] ph,
                        output int done_cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        done_cyc = 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) begin
                done_cyc = i + 1;
                break;
            end
            if (exp_q.size() == 0) begin
                chk("busy_beyond_stream", busy, 0);
                break;
            end
            chk("sr_out", sr_out, exp_q.pop_front());
            if (i == push_at) begin
                wr_en   = 1'b1;
                wr_sr   = psr;
                wr_hold = ph;
                repeat (int'(ph) + 1) exp_q.push_back(psr);
            end
            tick();
            wr_en = 1'b0;
        end
        if (done_cyc == 0) chk("play_timeout", busy, 0);
        chk("done_pulse", done, 1);
        chk("done_sr_out", sr_out, 0);
        chk("stream_drained", exp_q.size(), 0);
        exp_q.delete();
        model_occ = 0;
        tick();
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sr = 2'b00; wr_hold = 4'd0;
        start = 1'b0; q_sel = 1'b0; q_force = 1'b0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sr_out", sr_out, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_toggle", toggle_cnt, 0);
        chk("rst_illegal", illegal_cnt, 0);
        #4 rst = 1'b0;
        tick();

        // three entries, srff in the loop
        push(2'b10, 4'h0);
        push(2'b01, 4'h2);
        push(2'b10, 4'h1);
        play(-1, 2'b00, 4'h0, dc);
        chk("t1_done_cycle", dc, 7);
        chk("t1_toggle", toggle_cnt, 3);
        chk("t1_illegal", illegal_cnt, 0);
        repeat (3) tick();
        chk("t1_toggle_hold", toggle_cnt, 3);

        // start with nothing queued is ignored
        chk("es_empty", empty, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("es_busy", busy, 0);
            chk("es_done", done, 0);
            tick();
        end

        // fill to DEPTH, extra write dropped
        for (int i = 0; i < DEPTH; i++) begin
            logic [3:0] iv;
            iv = 4'(i);
            push(iv[1:0], 4'h0);
        end
        chk("fill_full", full, 1);
        push(2'b10, 4'h0);
        chk("fill_full_after_drop", full, 1);
        chk("fill_not_empty", empty, 0);
        play(-1, 2'b00, 4'h0, dc);
        chk("fill_done_cycle", dc, DEPTH + 1);
        chk("fill_illegal", illegal_cnt, 2);

        // illegal command held 5 cycles
        push(2'b11, 4'h4);
        play(-1, 2'b00, 4'h0, dc);
        chk("ill_done_cycle", dc, 6);
        chk("ill_cnt", illegal_cnt, 5);

        // push during RUN at occupancy 0 continues without a gap
        push(2'b10, 4'h2);
        play(0, 2'b01, 4'h1, dc);
        chk("mid_done_cycle", dc, 6);

        // asynchronous reset mid-playback
        push(2'b11, 4'hF);
        push(2'b10, 4'h3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mr_busy_pre", busy, 1);
        chk("mr_illegal_pre", illegal_cnt, 2);
        #2 rst = 1'b1;
        #1;
        chk("mr_sr_out", sr_out, 0);
        chk("mr_busy", busy, 0);
        chk("mr_illegal", illegal_cnt, 0);
        chk("mr_toggle", toggle_cnt, 0);
        chk("mr_empty", empty, 1);
        chk("mr_done", done, 0);
        #2 rst = 1'b0;
        exp_q.delete();
        model_occ = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mr_no_done", done, 0);
            chk("mr_idle", busy, 0);
        end

        // toggle counter saturation
        q_sel = 1'b1;
        push(2'b00, 4'hF);
        exp_q.delete();
        model_occ = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b1; wr_sr = 2'b00; wr_hold = 4'hF;
        begin
            int gaps;
            gaps = 0;
            for (int i = 0; i < 70100; i++) begin
                q_force = ~q_force;
                if (!busy) gaps++;
                tick();
            end
            wr_en = 1'b0;
            chk("sat_no_gap", gaps, 0);
        end
        for (int i = 0; i < 400 && busy; i++) tick();
        chk("sat_drained", busy, 0);
        chk("sat_toggle", toggle_cnt, 16'hFFFF);
        chk("sat_illegal", illegal_cnt, 0);
        q_sel = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
